// File: rtl/phase_frame_pkg.sv
// phase_frame_pkg: shared phase-frame constants, FSM state type and byte selector
package phase_frame_pkg;
  localparam logic [7:0] HDR_P1 = 8'h01;
  localparam logic [7:0] HDR_P2 = 8'h02;
  localparam logic [7:0] HDR_P3 = 8'h03;
  localparam logic [7:0] HDR_P4 = 8'h04;
  localparam int FRAME_LEN = 12;
  typedef enum logic {IDLE, SEND} tx_state_t;
  // Frame is four groups of {header, hi byte, lo byte}
  function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [15:0] p1, p2, p3, p4);
    logic [1:0] w;
    logic [1:0] r;
    logic [15:0] p;
    logic [7:0] h;
    w = idx < 4'd3 ? 2'd0 : idx < 4'd6 ? 2'd1 : idx < 4'd9 ? 2'd2 : 2'd3;
    r = 2'(idx - 4'(w) * 4'd3);
    p = w == 2'd0 ? p1 : w == 2'd1 ? p2 : w == 2'd2 ? p3 : p4;
    h = w == 2'd0 ? HDR_P1 : w == 2'd1 ? HDR_P2 : w == 2'd2 ? HDR_P3 : HDR_P4;
    return r == 2'd0 ? h : r == 2'd1 ? p[15:8] : p[7:0];
  endfunction
endpackage

// File: rtl/phase_tx_control_if.sv
// phase_tx_control_if: phase inputs, start request and UART TX handshake
interface phase_tx_control_if #(parameter int PHASE_W = 10);
  logic Start_Sig;
  logic [PHASE_W-1:0] phase_1, phase_2, phase_3, phase_4;
  logic TX_Done_Sig;
  logic TX_En_Sig;
  logic [7:0] TX_Data;
  logic Busy;
  logic Done_Sig;
  modport master(output Start_Sig, phase_1, phase_2, phase_3, phase_4, TX_Done_Sig,
                 input TX_En_Sig, TX_Data, Busy, Done_Sig);
  modport slave(input Start_Sig, phase_1, phase_2, phase_3, phase_4, TX_Done_Sig,
                output TX_En_Sig, TX_Data, Busy, Done_Sig);
endinterface

// File: rtl/phase_tx_control.sv
// phase_tx_control: serialises four phase words into the 12-byte frame for UART TX
module phase_tx_control
  import phase_frame_pkg::*;
(
  input logic CLK,
  input logic RST,
  phase_tx_control_if.slave bus
);
  tx_state_t state;
  logic [3:0] byte_idx;
  logic [15:0] sh [4];
  logic tx_en;
  logic [7:0] tx_data;
  logic done;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      byte_idx <= '0;
      sh <= '{default: '0};
      tx_en <= 1'b0;
      tx_data <= 8'h00;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (bus.Start_Sig) begin
          sh <= '{16'(bus.phase_1), 16'(bus.phase_2), 16'(bus.phase_3), 16'(bus.phase_4)};
          byte_idx <= '0;
          tx_data <= HDR_P1;
          tx_en <= 1'b1;
          state <= SEND;
        end
      end else if (bus.TX_Done_Sig) begin
        if (byte_idx == 4'(FRAME_LEN - 1)) begin
          tx_en <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
        end else begin
          byte_idx <= byte_idx + 4'd1;
          tx_data <= frame_byte(byte_idx + 4'd1, sh[0], sh[1], sh[2], sh[3]);
        end
      end
    end
  end
  assign bus.TX_En_Sig = tx_en;
  assign bus.Busy = tx_en;
  assign bus.TX_Data = tx_data;
  assign bus.Done_Sig = done;
endmodule

// File: tb/tb_phase_tx_control.sv
// tb_phase_tx_control: directed and random frames against a byte-list reference model
module tb_phase_tx_control;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  phase_tx_control_if #(.PHASE_W(10)) bus();
  phase_tx_control dut(.CLK(clk), .RST(rst), .bus(bus));
  int tests = 0, fails = 0;
  logic m_en = 0, m_done = 0;
  logic [7:0] m_data = 0;
  int m_pos = 0;
  logic [7:0] m_frame [12];
  logic [7:0] sent [$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic build(input logic [9:0] a, b, c, d);
    logic [15:0] p [4];
    p = '{16'(a), 16'(b), 16'(c), 16'(d)};
    for (int k = 0; k < 4; k++) begin
      m_frame[3*k]   = 8'(k + 1);
      m_frame[3*k+1] = 8'(p[k] >> 8);
      m_frame[3*k+2] = 8'(p[k] & 16'h00FF);
    end
  endtask
  task automatic set_phases(input logic [9:0] a, b, c, d);
    bus.phase_1 = a; bus.phase_2 = b; bus.phase_3 = c; bus.phase_4 = d;
  endtask
  task automatic step(input logic s, input logic d, input logic r);
    bus.Start_Sig = s; bus.TX_Done_Sig = d; rst = r;
    if (bus.TX_En_Sig && d && !r) sent.push_back(bus.TX_Data);
    @(posedge clk);
    if (r) begin
      m_en = 0; m_data = 0; m_done = 0; m_pos = 0;
    end else begin
      m_done = 0;
      if (!m_en) begin
        if (s) begin
          build(bus.phase_1, bus.phase_2, bus.phase_3, bus.phase_4);
          m_pos = 0; m_en = 1; m_data = m_frame[0];
        end
      end else if (d) begin
        if (m_pos == 11) begin
          m_en = 0; m_done = 1;
        end else begin
          m_pos++; m_data = m_frame[m_pos];
        end
      end
    end
    #1;
    check("en", 32'(bus.TX_En_Sig), 32'(m_en));
    check("busy", 32'(bus.Busy), 32'(m_en));
    check("data", 32'(bus.TX_Data), 32'(m_data));
    check("done", 32'(bus.Done_Sig), 32'(m_done));
  endtask
  task automatic run_frame(input int wt, input int chg_at, input int st_at, input int rst_at);
    sent.delete();
    step(1, 0, 0);
    for (int b = 0; b < 12; b++) begin
      for (int w = 0; w < wt; w++) step(b == st_at && w == 0, 0, 0);
      if (b == chg_at) set_phases(10'h111, 10'h111, 10'h111, 10'h111);
      if (b == rst_at) begin
        step(0, 0, 1);
        return;
      end
      step(0, 1, 0);
    end
  endtask
  task automatic check_sent(input string tag, input logic [7:0] exp [12]);
    check({tag, "_len"}, sent.size(), 12);
    for (int i = 0; i < 12 && i < sent.size(); i++) check(tag, 32'(sent[i]), 32'(exp[i]));
  endtask
  initial begin
    int cnt;
    logic [7:0] nom [12];
    logic [7:0] ones [12];
    nom  = '{8'h01, 8'h03, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h03, 8'h01, 8'h55, 8'h04, 8'h02, 8'hAA};
    ones = '{8'h01, 8'h01, 8'h11, 8'h02, 8'h01, 8'h11, 8'h03, 8'h01, 8'h11, 8'h04, 8'h01, 8'h11};
    set_phases(10'h3FF, 10'h000, 10'h155, 10'h2AA);
    bus.Start_Sig = 0; bus.TX_Done_Sig = 0;
    repeat (3) step(1, 0, 1);
    check("rst_en", 32'(bus.TX_En_Sig), 0);
    check("rst_data", 32'(bus.TX_Data), 0);
    step(0, 0, 0);
    check("idle_en", 32'(bus.TX_En_Sig), 0);
    run_frame(2, -1, -1, -1);
    check_sent("nominal", nom);
    check("nom_done", 32'(bus.Done_Sig), 1);
    step(0, 0, 0);
    check("done_once", 32'(bus.Done_Sig), 0);
    set_phases(10'h3FF, 10'h000, 10'h155, 10'h2AA);
    run_frame(1, 2, 5, -1);
    check_sent("snapshot", nom);
    check("gap_en", 32'(bus.TX_En_Sig), 0);
    run_frame(0, -1, -1, -1);
    check_sent("new_phase", ones);
    step(0, 0, 0);
    set_phases(10'h2AA, 10'h155, 10'h000, 10'h3FF);
    run_frame(1, -1, -1, 7);
    check("abort_en", 32'(bus.TX_En_Sig), 0);
    check("abort_done", 32'(bus.Done_Sig), 0);
    step(0, 0, 0);
    step(1, 0, 0);
    check("restart_hdr", 32'(bus.TX_Data), 32'h01);
    repeat (12) step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 0);
    cnt = 32'(bus.TX_En_Sig);
    for (int i = 0; i < 12; i++) begin
      step(0, 1, 0);
      cnt += 32'(bus.TX_En_Sig);
    end
    check("zero_wait_len", cnt, 12);
    for (int i = 0; i < 400; i++) begin
      set_phases(10'($urandom), 10'($urandom), 10'($urandom), 10'($urandom));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
